ibex_ex_wb_buffer: RTL

Two-entry result buffer between the execution block and the register-file write port. It captures each completed ALU or multiplier/divider result, arbitrates the shared write port against load writeback from the LSU (the LSU has priority), and retires buffered results in order. It also holds the sticky P-extension saturation flag (vxsat) and reports read-after-write hazards, or forwards data, to the ID stage.

---
 rtl/ibex_ex_wb_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/ibex_ex_wb_buffer.sv
// ibex_ex_wb_buffer: two-entry EX result buffer arbitrating the register-file write port against LSU loads
// Ports: ex_valid_i/rf_we_id_i/rf_waddr_id_i/result_ex_i push EX results; ready_o/empty_o report buffer state;
//        lsu_rf_* take priority on the write port rf_we_o/rf_waddr_o/rf_wdata_o; rf_raddr_{a,b}_i look up
//        buffered results for hazard_{a,b}_o or fwd_{a,b}_*; vxsat_* hold the sticky saturation flag.
// Build option: define IBEX_WB_FWD_EN to forward buffered data instead of raising hazards.
package ibex_pkg;
  typedef enum integer {
    RV32PNone = 0,
    RV32PFull = 1
  } rv32p_e;
endpackage

module ibex_ex_wb_buffer #(
  parameter ibex_pkg::rv32p_e RV32P = ibex_pkg::RV32PNone
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic        rf_we_id_i,
  input  logic [4:0]  rf_waddr_id_i,
  input  logic [31:0] result_ex_i,
  input  logic        vxsat_set_i,
  output logic        ready_o,
  output logic        empty_o,
  input  logic        lsu_rf_we_i,
  input  logic [4:0]  lsu_rf_waddr_i,
  input  logic [31:0] lsu_rf_wdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  input  logic [4:0]  rf_raddr_a_i,
  input  logic [4:0]  rf_raddr_b_i,
  output logic        hazard_a_o,
  output logic        hazard_b_o,
  output logic        fwd_a_valid_o,
  output logic        fwd_b_valid_o,
  output logic [31:0] fwd_a_data_o,
  output logic [31:0] fwd_b_data_o,
  input  logic        vxsat_wr_i,
  input  logic        vxsat_wdata_i,
  output logic        vxsat_o
);
  logic [4:0]  waddr_q [2];
  logic [31:0] wdata_q [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  count_q;
  logic        push, pop, newest;
  logic [4:0]  raddr [2];
  logic        hit [2];
  assign ready_o = ~count_q[1];
  assign empty_o = ~|count_q;
  assign push    = ex_valid_i & rf_we_id_i & ready_o & |rf_waddr_id_i;
  assign pop     = rst_ni & ~lsu_rf_we_i & |count_q;
  // when full the newer entry sits opposite the head; otherwise the head is the only entry
  assign newest  = count_q[1] ? ~rptr_q : rptr_q;
  assign rf_we_o    = rst_ni & (lsu_rf_we_i | |count_q);
  assign rf_waddr_o = ~rf_we_o ? '0 : lsu_rf_we_i ? lsu_rf_waddr_i : waddr_q[rptr_q];
  assign rf_wdata_o = ~rf_we_o ? '0 : lsu_rf_we_i ? lsu_rf_wdata_i : wdata_q[rptr_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr_q <= '{default: '0};
      wdata_q <= '{default: '0};
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        waddr_q[wptr_q] <= rf_waddr_id_i;
        wdata_q[wptr_q] <= result_ex_i;
        wptr_q          <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end
  assign raddr[0] = rf_raddr_a_i;
  assign raddr[1] = rf_raddr_b_i;
`ifdef IBEX_WB_FWD_EN
  logic [31:0] hdata [2];
`endif
  for (genvar i = 0; i < 2; i++) begin : g_lookup
    logic new_m, old_m;
    assign new_m  = |count_q & |raddr[i] & (waddr_q[newest] == raddr[i]);
    assign old_m  = count_q[1] & |raddr[i] & (waddr_q[rptr_q] == raddr[i]);
    assign hit[i] = new_m | old_m;
`ifdef IBEX_WB_FWD_EN
    assign hdata[i] = new_m ? wdata_q[newest] : old_m ? wdata_q[rptr_q] : '0;
`endif
  end
`ifdef IBEX_WB_FWD_EN
  assign hazard_a_o    = 1'b0;
  assign hazard_b_o    = 1'b0;
  assign fwd_a_valid_o = hit[0];
  assign fwd_b_valid_o = hit[1];
  assign fwd_a_data_o  = hdata[0];
  assign fwd_b_data_o  = hdata[1];
`else
  assign hazard_a_o    = hit[0];
  assign hazard_b_o    = hit[1];
  assign fwd_a_valid_o = 1'b0;
  assign fwd_b_valid_o = 1'b0;
  assign fwd_a_data_o  = '0;
  assign fwd_b_data_o  = '0;
`endif
  if (RV32P != ibex_pkg::RV32PNone) begin : g_vxsat
    logic vxsat_q;
    // a CSR write overrides a saturation reported in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) vxsat_q <= 1'b0;
      else vxsat_q <= vxsat_wr_i ? vxsat_wdata_i : (ex_valid_i & vxsat_set_i) | vxsat_q;
    end
    assign vxsat_o = vxsat_q;
  end else begin : g_no_vxsat
    logic unused_vxsat;
    assign unused_vxsat = ^{vxsat_set_i, vxsat_wr_i, vxsat_wdata_i};
    assign vxsat_o      = 1'b0;
  end
endmodule
